// File: rtl/clock_set_controller_if.sv
// clock_set_controller_if
// Bundles the button, live-time and edit-output signals of the time-set
// controller so the controller and its environment share one port.
//
// Signals:
//   btn_mode, btn_inc, btn_dec      debounced push-button levels, high = pressed
//   cur_h1, cur_h0, cur_m1, cur_m0  live BCD hh:mm from the timekeeping counter
//   run_en                          counter advance enable
//   load                            one-cycle load strobe for set_* into the counter
//   set_h1, set_h0, set_m1, set_m0  BCD hh:mm being edited
//   blank_mask                      per-digit blank (bit7..6 hours, bit5..4 minutes)
//   mode_state                      RUN=00, SET_HOUR=01, SET_MIN=10, COMMIT=11
//
// Modports:
//   master  environment side: drives buttons and live time, observes outputs
//   slave   controller side: consumes buttons and live time, drives outputs
interface clock_set_controller_if;

   logic       btn_mode;
   logic       btn_inc;
   logic       btn_dec;
   logic [3:0] cur_h1;
   logic [3:0] cur_h0;
   logic [3:0] cur_m1;
   logic [3:0] cur_m0;
   logic       run_en;
   logic       load;
   logic [3:0] set_h1;
   logic [3:0] set_h0;
   logic [3:0] set_m1;
   logic [3:0] set_m0;
   logic [7:0] blank_mask;
   logic [1:0] mode_state;

   modport master (
      output btn_mode, btn_inc, btn_dec,
      output cur_h1, cur_h0, cur_m1, cur_m0,
      input  run_en, load,
      input  set_h1, set_h0, set_m1, set_m0,
      input  blank_mask, mode_state
   );

   modport slave (
      input  btn_mode, btn_inc, btn_dec,
      input  cur_h1, cur_h0, cur_m1, cur_m0,
      output run_en, load,
      output set_h1, set_h0, set_m1, set_m0,
      output blank_mask, mode_state
   );

endinterface

// File: rtl/clock_set_controller.sv
// clock_set_controller
// Time-set controller for the eight-digit BCD timekeeping counter. Turns the
// mode/inc/dec buttons into an edit sequence RUN -> SET_HOUR -> SET_MIN ->
// COMMIT, freezes the counter while editing, steps the selected field with
// wrap and auto-repeat, blinks the field being edited and finally issues a
// one-cycle load of the edited hh:mm.
//
// Ports:
//   clock   system clock, the only clock
//   reset   synchronous, active-high
//   bus     clock_set_controller_if.slave (buttons, live time, edit outputs)
//
// Parameters:
//   BLINK_BITS    width of the free-running blink counter, MSB = blink phase
//   REPEAT_DELAY  hold cycles after a press before the first auto-repeat step
//   REPEAT_RATE   cycles between subsequent auto-repeat steps
//   TIMEOUT       idle cycles in a SET state before the edit is abandoned
module clock_set_controller #(
   parameter int          BLINK_BITS   = 24,
   parameter logic [23:0] REPEAT_DELAY = 24'd5_000_000,
   parameter logic [23:0] REPEAT_RATE  = 24'd2_000_000,
   parameter logic [31:0] TIMEOUT      = 32'd1_000_000_000
) (
   input logic                  clock,
   input logic                  reset,
   clock_set_controller_if.slave bus
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10,
      COMMIT   = 2'b11
   } state_t;

   state_t                state_q;
   logic                  prevMode_q;
   logic                  prevInc_q;
   logic                  prevDec_q;
   logic [7:0]            setHour_q;
   logic [7:0]            setMin_q;
   logic [23:0]           holdCnt_q;
   logic [23:0]           holdCnt_d;
   logic [31:0]           idleCnt_q;
   logic [31:0]           idleCnt_d;
   logic [BLINK_BITS-1:0] blink_q;

   logic modeRise;
   logic incRise;
   logic decRise;
   logic anyRise;
   logic inSet;
   logic repeatStep;
   logic stepUp;
   logic stepDown;
   logic timeoutHit;
   logic blinkMsb;

   // Snapshot cleanup: anything that is not a legal 00..23 hour becomes 00.
   function automatic logic [7:0] cleanHour(input logic [7:0] h);
      if (h[7:4] < 4'd2 && h[3:0] <= 4'd9)
         return h;
      else if (h[7:4] == 4'd2 && h[3:0] <= 4'd3)
         return h;
      else
         return 8'h00;
   endfunction

   // Snapshot cleanup: anything that is not a legal 00..59 minute becomes 00.
   function automatic logic [7:0] cleanMin(input logic [7:0] m);
      if (m[7:4] <= 4'd5 && m[3:0] <= 4'd9)
         return m;
      else
         return 8'h00;
   endfunction

   // Hour wrap is tested on the full two-digit value, so 23 -> 00 and not 24.
   function automatic logic [7:0] hourUp(input logic [7:0] h);
      if (h == 8'h23)
         return 8'h00;
      else if (h[3:0] == 4'd9)
         return {h[7:4] + 4'd1, 4'd0};
      else
         return {h[7:4], h[3:0] + 4'd1};
   endfunction

   // Decrement with borrow from tens; 00 wraps back to 23.
   function automatic logic [7:0] hourDown(input logic [7:0] h);
      if (h == 8'h00)
         return 8'h23;
      else if (h[3:0] == 4'd0)
         return {h[7:4] - 4'd1, 4'd9};
      else
         return {h[7:4], h[3:0] - 4'd1};
   endfunction

   // Minutes wrap 59 -> 00 with no carry into the hour field.
   function automatic logic [7:0] minUp(input logic [7:0] m);
      if (m == 8'h59)
         return 8'h00;
      else if (m[3:0] == 4'd9)
         return {m[7:4] + 4'd1, 4'd0};
      else
         return {m[7:4], m[3:0] + 4'd1};
   endfunction

   // Minutes wrap 00 -> 59 with no borrow from the hour field.
   function automatic logic [7:0] minDown(input logic [7:0] m);
      if (m == 8'h00)
         return 8'h59;
      else if (m[3:0] == 4'd0)
         return {m[7:4] - 4'd1, 4'd9};
      else
         return {m[7:4], m[3:0] - 4'd1};
   endfunction

   // Rising-edge detection against last cycle's button levels. Because the
   // prev registers reset to 1, a button held through reset gives no edge.
   always_comb begin
      modeRise = bus.btn_mode & ~prevMode_q;
      incRise  = bus.btn_inc  & ~prevInc_q;
      decRise  = bus.btn_dec  & ~prevDec_q;
      anyRise  = modeRise | incRise | decRise;
      inSet    = (state_q == SET_HOUR) || (state_q == SET_MIN);
   end

   // Auto-repeat hold counter. A fresh press restarts it, pressing both
   // buttons or releasing parks it at zero, and a single held button counts
   // up. Hitting REPEAT_DELAY fires a step and reloads to
   // REPEAT_DELAY - REPEAT_RATE so later steps come every REPEAT_RATE cycles.
   always_comb begin
      holdCnt_d  = '0;
      repeatStep = 1'b0;
      if (inSet && !incRise && !decRise && (bus.btn_inc ^ bus.btn_dec)) begin
         if (holdCnt_q + 24'd1 == REPEAT_DELAY) begin
            repeatStep = 1'b1;
            holdCnt_d  = REPEAT_DELAY - REPEAT_RATE;
         end else begin
            holdCnt_d = holdCnt_q + 24'd1;
         end
      end
   end

   // A step needs exactly one of inc/dec; both together cancel. The idle
   // counter restarts on any press (auto-repeat does not count as activity)
   // and the edit is abandoned when it reaches TIMEOUT.
   always_comb begin
      stepUp     = (incRise & ~bus.btn_dec) | (repeatStep & bus.btn_inc);
      stepDown   = (decRise & ~bus.btn_inc) | (repeatStep & bus.btn_dec);
      idleCnt_d  = anyRise ? 32'd0 : idleCnt_q + 32'd1;
      timeoutHit = inSet && !anyRise && (idleCnt_d == TIMEOUT);
   end

   // Main edit FSM together with the edit registers, button history, repeat
   // and idle counters and the free-running blink counter. A mode press
   // always wins over a step in the same cycle, and a timeout returns to RUN
   // without touching set_* or pulsing load.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= RUN;
         prevMode_q <= 1'b1;
         prevInc_q  <= 1'b1;
         prevDec_q  <= 1'b1;
         setHour_q  <= 8'h00;
         setMin_q   <= 8'h00;
         holdCnt_q  <= '0;
         idleCnt_q  <= '0;
         blink_q    <= '0;
      end else begin
         prevMode_q <= bus.btn_mode;
         prevInc_q  <= bus.btn_inc;
         prevDec_q  <= bus.btn_dec;
         holdCnt_q  <= holdCnt_d;
         blink_q    <= blink_q + {{(BLINK_BITS-1){1'b0}}, 1'b1};

         case (state_q)
            RUN: begin
               idleCnt_q <= '0;
               if (modeRise) begin
                  state_q   <= SET_HOUR;
                  setHour_q <= cleanHour({bus.cur_h1, bus.cur_h0});
                  setMin_q  <= cleanMin({bus.cur_m1, bus.cur_m0});
               end
            end

            SET_HOUR: begin
               if (modeRise) begin
                  state_q   <= SET_MIN;
                  idleCnt_q <= '0;
               end else if (timeoutHit) begin
                  state_q   <= RUN;
                  idleCnt_q <= '0;
               end else begin
                  idleCnt_q <= idleCnt_d;
                  if (stepUp)
                     setHour_q <= hourUp(setHour_q);
                  else if (stepDown)
                     setHour_q <= hourDown(setHour_q);
               end
            end

            SET_MIN: begin
               if (modeRise) begin
                  state_q   <= COMMIT;
                  idleCnt_q <= '0;
               end else if (timeoutHit) begin
                  state_q   <= RUN;
                  idleCnt_q <= '0;
               end else begin
                  idleCnt_q <= idleCnt_d;
                  if (stepUp)
                     setMin_q <= minUp(setMin_q);
                  else if (stepDown)
                     setMin_q <= minDown(setMin_q);
               end
            end

            default: begin
               state_q   <= RUN;
               idleCnt_q <= '0;
            end
         endcase
      end
   end

   // Outputs are pure decodes of registers, so they change only in the
   // cycle after the edge that moved the state.
   assign blinkMsb       = blink_q[BLINK_BITS-1];
   assign bus.run_en     = (state_q == RUN);
   assign bus.load       = (state_q == COMMIT);
   assign bus.mode_state = state_q;
   assign bus.set_h1     = setHour_q[7:4];
   assign bus.set_h0     = setHour_q[3:0];
   assign bus.set_m1     = setMin_q[7:4];
   assign bus.set_m0     = setMin_q[3:0];
   assign bus.blank_mask = (state_q == SET_HOUR) ? {blinkMsb, blinkMsb, 6'b0} :
                           (state_q == SET_MIN)  ? {2'b0, blinkMsb, blinkMsb, 4'b0} :
                                                   8'h00;

endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller
// Self-checking bench for clock_set_controller, built with small parameters
// (BLINK_BITS=4, REPEAT_DELAY=10, REPEAT_RATE=4, TIMEOUT=50). A table of
// one-cycle vectors covers wrap, priority and snapshot cleanup; hand-written
// sequences cover reset, the long edit, auto-repeat, timeout and blink.
module tb_clock_set_controller;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [3:0] tbBlink;
   int total = 0;
   int bad = 0;

   clock_set_controller_if bus ();

   clock_set_controller #(
      .BLINK_BITS   (4),
      .REPEAT_DELAY (24'd10),
      .REPEAT_RATE  (24'd4),
      .TIMEOUT      (32'd50)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic        mode;
      logic        inc;
      logic        dec;
      logic [15:0] cur;
      logic [1:0]  expState;
      logic        expRun;
      logic        expLoad;
      logic [15:0] expSet;
   } vec_t;

   vec_t vecs[$];

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Independent copy of the blink phase: cycles since reset, 4 bits.
   always @(posedge clock) begin
      if (reset)
         tbBlink <= 4'd0;
      else
         tbBlink <= tbBlink + 4'd1;
   end

   // Safety net so the run always ends even if the design stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void addVec(input logic m, input logic i, input logic d,
                                  input logic [15:0] c, input logic [1:0] s,
                                  input logic r, input logic l, input logic [15:0] e);
      vec_t v;
      v.mode = m; v.inc = i; v.dec = d; v.cur = c;
      v.expState = s; v.expRun = r; v.expLoad = l; v.expSet = e;
      vecs.push_back(v);
   endfunction

   function automatic logic [7:0] toBcd(input int v);
      logic [7:0] b;
      b[7:4] = 4'((v / 10) % 10);
      b[3:0] = 4'(v % 10);
      return b;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Compares every output; blank_mask expectation follows the expected
   // state and the bench's own blink phase.
   task automatic checkOutput(input string tag, input logic [1:0] expState,
                              input logic expRun, input logic expLoad,
                              input logic [15:0] expSet);
      logic [7:0] expBlank;
      expBlank = 8'h00;
      if (expState == 2'b01) expBlank = {tbBlink[3], tbBlink[3], 6'b0};
      if (expState == 2'b10) expBlank = {2'b0, tbBlink[3], tbBlink[3], 4'b0};
      checkValue({tag, ".state"}, 32'(bus.mode_state), 32'(expState));
      checkValue({tag, ".run_en"}, 32'(bus.run_en), 32'(expRun));
      checkValue({tag, ".load"}, 32'(bus.load), 32'(expLoad));
      checkValue({tag, ".set"},
                 32'({bus.set_h1, bus.set_h0, bus.set_m1, bus.set_m0}), 32'(expSet));
      checkValue({tag, ".blank"}, 32'(bus.blank_mask), 32'(expBlank));
   endtask

   // Drive inputs on the falling edge, let one rising edge sample them and
   // look at the outputs shortly after that edge.
   task automatic applyStimulus(input logic m, input logic i, input logic d,
                                input logic [15:0] c);
      @(negedge clock);
      bus.btn_mode = m;
      bus.btn_inc  = i;
      bus.btn_dec  = d;
      {bus.cur_h1, bus.cur_h0, bus.cur_m1, bus.cur_m0} = c;
      @(posedge clock);
      #1;
   endtask

   initial begin
      int steps;
      int hour;
      int minute;
      logic loadSeen;
      logic earlyExit;
      logic reached;

      bus.btn_mode = 1'b1;
      bus.btn_inc  = 1'b0;
      bus.btn_dec  = 1'b0;
      {bus.cur_h1, bus.cur_h0, bus.cur_m1, bus.cur_m0} = 16'h0000;

      // Reset with mode held; holding it afterwards must not start an edit.
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset", 2'b00, 1'b1, 1'b0, 16'h0000);
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
         checkOutput("heldMode", 2'b00, 1'b1, 1'b0, 16'h0000);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("released", 2'b00, 1'b1, 1'b0, 16'h0000);

      // Directed one-cycle vectors.
      addVec(1,0,0,16'h2300, 2'b01,0,0,16'h2300);
      addVec(0,0,0,16'h2300, 2'b01,0,0,16'h2300);
      addVec(0,1,0,16'h2300, 2'b01,0,0,16'h0000);
      addVec(0,0,0,16'h2300, 2'b01,0,0,16'h0000);
      addVec(0,0,1,16'h2300, 2'b01,0,0,16'h2300);
      addVec(0,0,0,16'h2300, 2'b01,0,0,16'h2300);
      addVec(0,0,1,16'h2300, 2'b01,0,0,16'h2200);
      addVec(0,0,0,16'h2300, 2'b01,0,0,16'h2200);
      addVec(0,1,0,16'h2300, 2'b01,0,0,16'h2300);
      addVec(0,0,0,16'h2300, 2'b01,0,0,16'h2300);
      addVec(0,1,1,16'h2300, 2'b01,0,0,16'h2300);
      addVec(0,0,0,16'h2300, 2'b01,0,0,16'h2300);
      addVec(1,1,0,16'h2300, 2'b10,0,0,16'h2300);
      addVec(0,0,0,16'h2300, 2'b10,0,0,16'h2300);
      addVec(0,0,1,16'h2300, 2'b10,0,0,16'h2359);
      addVec(0,0,0,16'h2300, 2'b10,0,0,16'h2359);
      addVec(0,1,0,16'h2300, 2'b10,0,0,16'h2300);
      addVec(0,0,0,16'h2300, 2'b10,0,0,16'h2300);
      addVec(0,1,0,16'h2300, 2'b10,0,0,16'h2301);
      addVec(0,0,0,16'h2300, 2'b10,0,0,16'h2301);
      addVec(1,0,0,16'h2300, 2'b11,0,1,16'h2301);
      addVec(0,0,0,16'h2300, 2'b00,1,0,16'h2301);
      addVec(1,0,0,16'h2775, 2'b01,0,0,16'h0000);
      addVec(0,0,0,16'h2775, 2'b01,0,0,16'h0000);
      addVec(1,0,0,16'h2775, 2'b10,0,0,16'h0000);
      addVec(0,0,0,16'h2775, 2'b10,0,0,16'h0000);
      addVec(1,0,0,16'h2775, 2'b11,0,1,16'h0000);
      addVec(0,0,0,16'h2775, 2'b00,1,0,16'h0000);
      addVec(1,0,0,16'h195A, 2'b01,0,0,16'h1900);
      addVec(0,0,0,16'h195A, 2'b01,0,0,16'h1900);
      addVec(1,0,0,16'h195A, 2'b10,0,0,16'h1900);
      addVec(0,0,0,16'h195A, 2'b10,0,0,16'h1900);
      addVec(1,0,0,16'h195A, 2'b11,0,1,16'h1900);
      addVec(0,0,0,16'h195A, 2'b00,1,0,16'h1900);
      addVec(1,0,0,16'h1F30, 2'b01,0,0,16'h0030);
      addVec(0,0,0,16'h1F30, 2'b01,0,0,16'h0030);
      addVec(1,0,0,16'h1F30, 2'b10,0,0,16'h0030);
      addVec(0,0,0,16'h1F30, 2'b10,0,0,16'h0030);
      addVec(1,0,0,16'h1F30, 2'b11,0,1,16'h0030);
      addVec(0,0,0,16'h1F30, 2'b00,1,0,16'h0030);
      addVec(1,0,0,16'h0A45, 2'b01,0,0,16'h0045);
      addVec(0,0,0,16'h0A45, 2'b01,0,0,16'h0045);
      addVec(1,0,0,16'h0A45, 2'b10,0,0,16'h0045);
      addVec(0,0,0,16'h0A45, 2'b10,0,0,16'h0045);
      addVec(1,0,0,16'h0A45, 2'b11,0,1,16'h0045);
      addVec(0,0,0,16'h0A45, 2'b00,1,0,16'h0045);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].mode, vecs[i].inc, vecs[i].dec, vecs[i].cur);
         checkOutput($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expRun,
                     vecs[i].expLoad, vecs[i].expSet);
      end

      // Full edit: 15:48 -> inc x9 -> 00, dec x49 -> 59, commit 00:59.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h1548);
      checkOutput("editEnter", 2'b01, 1'b0, 1'b0, 16'h1548);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h1548);
      hour = 15;
      for (int k = 0; k < 9; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 16'h1548);
         hour = (hour + 1) % 24;
         checkOutput($sformatf("editInc%0d", k), 2'b01, 1'b0, 1'b0, {toBcd(hour), 8'h48});
         applyStimulus(1'b0, 1'b0, 1'b0, 16'h1548);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h1548);
      checkOutput("editMin", 2'b10, 1'b0, 1'b0, 16'h0048);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h1548);
      minute = 48;
      for (int k = 0; k < 49; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 16'h1548);
         minute = (minute + 59) % 60;
         checkOutput($sformatf("editDec%0d", k), 2'b10, 1'b0, 1'b0, {8'h00, toBcd(minute)});
         applyStimulus(1'b0, 1'b0, 1'b0, 16'h1548);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h1548);
      checkOutput("editCommit", 2'b11, 1'b0, 1'b1, 16'h0059);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h1548);
      checkOutput("editRun", 2'b00, 1'b1, 1'b0, 16'h0059);

      // Auto-repeat: hold inc 30 cycles in SET_MIN from 10.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h1210);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h1210);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h1210);
      checkOutput("rptEnter", 2'b10, 1'b0, 1'b0, 16'h1210);
      steps = 0;
      for (int k = 0; k < 30; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 16'h1210);
         if (k == 0 || (k >= 10 && (k - 10) % 4 == 0))
            steps++;
         checkOutput($sformatf("rptHold%0d", k), 2'b10, 1'b0, 1'b0,
                     {8'h12, toBcd(10 + steps)});
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h1210);
      checkOutput("rptRelease", 2'b10, 1'b0, 1'b0, 16'h1216);
      for (int k = 0; k < 15; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 16'h1210);
         checkOutput($sformatf("rptBoth%0d", k), 2'b10, 1'b0, 1'b0, 16'h1216);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h1210);

      // Let SET_MIN time out: back to RUN, no load, edit value kept.
      loadSeen = 1'b0;
      reached  = 1'b0;
      for (int k = 0; k < 80 && !reached; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 16'h1210);
         if (bus.load) loadSeen = 1'b1;
         if (bus.mode_state == 2'b00) reached = 1'b1;
      end
      checkValue("minTimeoutReached", 32'(reached), 32'd1);
      checkValue("minTimeoutNoLoad", 32'(loadSeen), 32'd0);
      checkOutput("minTimeoutRun", 2'b00, 1'b1, 1'b0, 16'h1216);

      // Exact SET_HOUR timeout: RUN exactly 50 cycles after entry.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0815);
      checkOutput("toEnter", 2'b01, 1'b0, 1'b0, 16'h0815);
      earlyExit = 1'b0;
      loadSeen  = 1'b0;
      for (int k = 1; k < 50; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 16'h0815);
         if (bus.mode_state != 2'b01) earlyExit = 1'b1;
         if (bus.load) loadSeen = 1'b1;
      end
      checkValue("toNotEarly", 32'(earlyExit), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0815);
      checkValue("toNoLoad", 32'(loadSeen | bus.load), 32'd0);
      checkOutput("toAt50", 2'b00, 1'b1, 1'b0, 16'h0815);

      // Press at cycle 40 restarts the idle count: still SET at 60, RUN at 90.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0815);
      checkOutput("to2Enter", 2'b01, 1'b0, 1'b0, 16'h0815);
      for (int k = 1; k <= 89; k++) begin
         applyStimulus(1'b0, (k == 40), 1'b0, 16'h0815);
         if (k == 60) checkOutput("to2At60", 2'b01, 1'b0, 1'b0, 16'h0915);
         if (k == 89) checkOutput("to2At89", 2'b01, 1'b0, 1'b0, 16'h0915);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0815);
      checkOutput("to2At90", 2'b00, 1'b1, 1'b0, 16'h0915);

      // Blink: SET_HOUR and SET_MIN masks follow the phase, RUN stays dark.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0720);
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 16'h0720);
         checkOutput($sformatf("blinkHour%0d", k), 2'b01, 1'b0, 1'b0, 16'h0720);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0720);
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 16'h0720);
         checkOutput($sformatf("blinkMin%0d", k), 2'b10, 1'b0, 1'b0, 16'h0720);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0720);
      checkOutput("blinkCommit", 2'b11, 1'b0, 1'b1, 16'h0720);
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 16'h0720);
         checkOutput($sformatf("blinkRun%0d", k), 2'b00, 1'b1, 1'b0, 16'h0720);
      end

      // Reset in the middle of an edit: straight to RUN, no load.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h1111);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h1111);
      checkOutput("midEdit", 2'b01, 1'b0, 1'b0, 16'h1211);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("midReset", 2'b00, 1'b1, 1'b0, 16'h0000);
      @(negedge clock);
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
